// File: rtl/bcd_display_scan_ctrl_if.sv
// rtl/bcd_display_scan_ctrl_if.sv - request and display bundle for bcd_display_scan_ctrl
interface bcd_display_scan_ctrl_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] bin_in;
  logic             load;
  logic             blank_lz;
  logic [3:0]       bcd_out;
  logic [3:0]       digit_en;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output bin_in, load, blank_lz,
    input  bcd_out, digit_en, busy, done, ovf
  );

  modport slave (
    input  bin_in, load, blank_lz,
    output bcd_out, digit_en, busy, done, ovf
  );
endinterface

// File: rtl/bcd_display_scan_ctrl.sv
// rtl/bcd_display_scan_ctrl.sv - binary to BCD converter with four-digit multiplexed display scan
module bcd_display_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int BIN_W       = 14
) (
  input logic                    clk,
  input logic                    rst,
  bcd_display_scan_ctrl_if.slave bus
);
  localparam int              PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BIN_W-1:0] BIN_MAX   = BIN_W'(9999);
  localparam logic [3:0]      SHIFT_LAST = 4'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [15:0]      work;
  logic [15:0]      work_adj;
  logic [15:0]      disp;
  logic [3:0]       shift_cnt;
  logic             busy_r;
  logic             done_r;
  logic             ovf_r;
  logic [PW-1:0]    presc;
  logic [1:0]       scan_idx;
  logic [3:0]       zero;
  logic [3:0]       lead;

  always_comb begin
    work_adj = work;
    for (int i = 0; i < 4; i++) begin
      if (work[i*4 +: 4] >= 4'd5)
        work_adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
    end
  end

  // Out-of-range inputs saturate so the display never shows a non-decimal nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      work      <= '0;
      disp      <= '0;
      shift_cnt <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            if (bus.bin_in > BIN_MAX) begin
              shreg <= BIN_MAX;
              ovf_r <= 1'b1;
            end else begin
              shreg <= bus.bin_in;
              ovf_r <= 1'b0;
            end
            work      <= '0;
            shift_cnt <= '0;
            busy_r    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          work      <= {work_adj[14:0], shreg[BIN_W-1]};
          shreg     <= {shreg[BIN_W-2:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == SHIFT_LAST)
            state <= COMMIT;
        end
        COMMIT: begin
          disp   <= work;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (presc == PRESC_LAST) begin
      presc    <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // lead[k]: digit k and every higher digit are zero; units is never a leading zero.
  always_comb begin
    for (int i = 0; i < 4; i++)
      zero[i] = (disp[i*4 +: 4] == 4'd0);
    lead[3] = zero[3];
    lead[2] = lead[3] & zero[2];
    lead[1] = lead[2] & zero[1];
    lead[0] = 1'b0;
  end

  assign bus.bcd_out  = disp[{scan_idx, 2'b00} +: 4];
  assign bus.digit_en = (bus.blank_lz && lead[scan_idx]) ? 4'b1111 : ~(4'b0001 << scan_idx);
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// tb/tb_bcd_display_scan_ctrl.sv - scoreboard bench for bcd_display_scan_ctrl
module tb_bcd_display_scan_ctrl;
  localparam int RD = 4;
  localparam int BW = 14;

  typedef struct packed {
    logic [15:0] digits;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic        rst_q   = 1'b0;
  logic        started = 1'b0;
  int          cyc     = 0;
  logic [15:0] mdig    = '0;

  always #5 clk = ~clk;

  bcd_display_scan_ctrl_if #(.BIN_W(BW)) bus ();

  bcd_display_scan_ctrl #(.REFRESH_DIV(RD), .BIN_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t to_exp(int v);
    exp_t e;
    int   s;
    s        = (v > 9999) ? 9999 : v;
    e.digits = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    e.ovf    = (v > 9999);
    return e;
  endfunction

  // Cycle count since the last reset edge gives the expected scan position.
  always @(posedge clk) begin
    rst_q   <= rst;
    started <= started | rst;
    cyc     <= rst ? 0 : cyc + 1;
  end

  always @(negedge clk) begin
    if (started) begin
      automatic logic [15:0] cur = mdig;
      automatic exp_t        e;
      automatic int          k;
      automatic logic        allz;
      automatic logic [3:0]  exp_en;
      if (rst_q) begin
        cur = '0;
        sb.delete();
      end else if (bus.done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done cyc=%0d got=done exp=no_pending_load", cyc);
        end else begin
          e   = sb.pop_front();
          cur = e.digits;
          checks++;
          if (bus.ovf !== e.ovf) begin
            errors++;
            $display("FAIL sb_ovf got=%b exp=%b", bus.ovf, e.ovf);
          end
        end
      end
      mdig <= cur;
      k    = (cyc / RD) % 4;
      allz = 1'b1;
      for (int j = k; j < 4; j++)
        if (cur[j*4 +: 4] != 4'd0) allz = 1'b0;
      exp_en = (bus.blank_lz === 1'b1 && k > 0 && allz) ? 4'b1111 : ~(4'b0001 << k);
      checks++;
      if (bus.digit_en !== exp_en) begin
        errors++;
        $display("FAIL scan_digit_en cyc=%0d got=%b exp=%b", cyc, bus.digit_en, exp_en);
      end
      checks++;
      if (bus.bcd_out !== cur[k*4 +: 4]) begin
        errors++;
        $display("FAIL scan_bcd_out cyc=%0d pos=%0d got=%0d exp=%0d", cyc, k, bus.bcd_out, cur[k*4 +: 4]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(int v);
    bus.bin_in = BW'(v);
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    sb.push_back(to_exp(v));
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.load     = 1'b1;
    bus.bin_in   = BW'(1234);
    bus.blank_lz = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.digit_en !== 4'b1110 || bus.bcd_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_display got=%b/%0d exp=1110/0", bus.digit_en, bus.bcd_out);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b%b%b exp=000", bus.busy, bus.done, bus.ovf);
    end
    rst      = 1'b0;
    bus.load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_conv cycle=%0d got=%b%b exp=00", i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_conversion(int v);
    int n;
    do_load(v);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL conv_busy_start val=%0d got=%b exp=1", v, bus.busy);
    end
    n = 0;
    do begin
      tick();
      n++;
      if (bus.done !== 1'b1 && n < 15) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL conv_busy val=%0d edge=N+%0d got=%b exp=1", v, n, bus.busy);
        end
      end
    end while (bus.done !== 1'b1 && n < 40);
    checks++;
    if (n != 15 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL conv_latency val=%0d got=%0d busy=%b exp=15 busy=0", v, n, bus.busy);
    end
    checks++;
    if (bus.ovf !== (v > 9999)) begin
      errors++;
      $display("FAIL conv_ovf val=%0d got=%b exp=%b", v, bus.ovf, (v > 9999));
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL conv_done_pulse val=%0d got=%b exp=0", v, bus.done);
    end
    repeat (16) tick();
  endtask

  task automatic test_busy_reject();
    int n;
    do_load(1234);
    repeat (4) tick();
    bus.bin_in = BW'(5678);
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    n = 5;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL busy_reject_latency got=%0d exp=15", n);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL busy_reject_second cycle=%0d got=%b%b exp=00", i, bus.busy, bus.done);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL busy_reject_sb got=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_scan_blank();
    int n_off;
    bus.blank_lz = 1'b0;
    test_conversion(7);
    bus.blank_lz = 1'b1;
    n_off = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.digit_en === 4'b1111) n_off++;
    end
    checks++;
    if (n_off != 12) begin
      errors++;
      $display("FAIL blank_seven got=%0d exp=12", n_off);
    end
    test_conversion(0);
    n_off = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.digit_en === 4'b1110 && bus.bcd_out === 4'd0) n_off++;
    end
    checks++;
    if (n_off != 4) begin
      errors++;
      $display("FAIL blank_zero_units got=%0d exp=4", n_off);
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_load(9876);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_abort cycle=%0d got=%b%b exp=00", i, bus.busy, bus.done);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_sb got=%0d exp=0", sb.size());
    end
    test_conversion(55);
  endtask

  task automatic test_back_to_back();
    int n;
    do_load(300);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done !== 1'b1 && n < 40);
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL b2b_first got=%0d exp=15", n);
    end
    do_load(4321);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got=%b exp=1", bus.busy);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done !== 1'b1 && n < 40);
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL b2b_second got=%0d exp=15", n);
    end
    repeat (17) tick();
  endtask

  initial begin
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.bin_in   = '0;
    bus.blank_lz = 1'b0;
    test_reset();
    test_conversion(1234);
    test_conversion(0);
    test_conversion(9999);
    test_conversion(1000);
    test_conversion(10000);
    test_conversion(16383);
    test_conversion(42);
    test_busy_reject();
    test_scan_blank();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_display_scan_ctrl.md
Name: bcd_display_scan_ctrl

Overview:
- Converts a binary count (0-9999) to four BCD digits: units, tens, hundreds, thousands.
- Uses an iterative double-dabble sequencer for the conversion.
- Time-multiplexes the four digits onto one shared decoder_7_seg instance, so one decoder drives all four common-anode displays.
- Sits between the counting/arithmetic logic and the 7-segment decoder/anode pins.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays enabled (1 kHz per digit at 50 MHz); minimum 2.
- BIN_W, 14: width of bin_in. Fixed at 14 for the 0-9999 range.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bin_in  input  BIN_W  binary value to convert; sampled only when load is accepted.
- load  input  1  conversion request; accepted only in IDLE.
- blank_lz  input  1  1 = blank leading zeros.
- bcd_out  output  4  BCD digit for the currently scanned position; feeds decoder_7_seg.decoder_in.
- digit_en  output  4  active-low anode enables, one-hot. Bit 0 = units, bit 1 = tens, bit 2 = hundreds, bit 3 = thousands.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when new digits are committed.
- ovf  output  1  last accepted bin_in exceeded 9999.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE; shift counter and prescaler go to 0; scan index goes to 0.
  - Displayed digits go to 0; busy, done and ovf go to 0.
  - digit_en = 4'b1110 and bcd_out = 0 in the cycle after the edge.
  - rst has priority over every other event, including mid-conversion: the conversion aborts and no done pulse is issued.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE, load = 1 at edge N:
  - Capture bin_in into the shift register. If bin_in > 9999, capture 9999 instead and set ovf = 1; otherwise clear ovf.
  - Clear the BCD working register and go to SHIFT.
  - busy = 1 from edge N.
- SHIFT, one bit per cycle, 14 cycles (edges N+1 .. N+14):
  - Each cycle, add 3 to every working BCD nibble >= 5.
  - Then shift {bcd, bin} left by one, MSB of bin first.
  - After the 14th shift, go to COMMIT.
- COMMIT (edge N+15):
  - Copy the working nibbles into the four display registers in a single edge.
  - done = 1 for exactly one cycle; busy = 0; return to IDLE.
- Latency:
  - load accepted at edge N gives done high in the cycle after edge N+15.
  - New digits are visible on bcd_out from that same cycle.
- Load handling:
  - load while busy is ignored: not queued, and bin_in changes have no effect.
  - load in the done cycle (state IDLE) is accepted.
- Display registers change only at COMMIT or reset. Scanning continues during a conversion and keeps showing the previous value.
- Scanner (independent of the FSM):
  - The prescaler counts 0..REFRESH_DIV-1 and wraps to 0.
  - At the terminal count, the scan index advances 0→1→2→3→0.
  - bcd_out is the display register selected by the scan index.
  - digit_en = ~(4'b0001 << index), unless the position is blanked, in which case digit_en = 4'b1111.
- Leading-zero blanking (blank_lz = 1):
  - Position k (k = 1..3) is blanked when digit k and all higher digits are 0.
  - Position 0 is never blanked, so value 0 shows "0".
  - blank_lz is evaluated combinationally every cycle.
- Width rules: all BCD arithmetic is 4 bits per nibble. No nibble exceeds 9 after COMMIT.

Test Plan:
- Reset: hold rst for 2 cycles with load = 1 → digit_en = 4'b1110, bcd_out = 0, busy = 0, done = 0, ovf = 0; no conversion starts.
- Conversion: bin_in = 1234, load pulsed at edge N → busy = 1 for cycles N..N+15, done high only after edge N+15. Digit registers read units = 4, tens = 3, hundreds = 2, thousands = 1. Also check 0 → 0000, 9999 → 9999, 1000 → 1/0/0/0.
- Overflow: bin_in = 10000, then 16383 → digits 9999 and ovf = 1. A following load of 42 → 0042 and ovf = 0.
- Busy-load rejection: load 1234, then pulse load with 5678 at edge N+5 → done only once (edge N+15) with 1234, and no second busy period.
- Scan and blanking (REFRESH_DIV = 4), value 7:
  - With blank_lz = 0: index advances every 4 cycles; digit_en cycles 1110, 1101, 1011, 0111, then wraps; bcd_out = 7, 0, 0, 0.
  - With blank_lz = 1: digit_en = 1110 then 1111 for the tens, hundreds and thousands slots.
  - Value 0 with blank_lz = 1: the units slot shows 0 with digit_en = 1110.
- Reset mid-conversion: load 9876, assert rst at edge N+7 → no done pulse; digits read 0000; the next load of 55 converts normally to 0055.
